// File: rtl/hls_drv_pkg.sv
// -----------------------------------------------------------------------------
// hls_drv_pkg
// Shared definitions for the ap_ctrl_hs caller-side driver (hls_macc_drv):
//   - drv_state_e : controller FSM states
//   - VLD_OUT*    : bit positions of the result-valid mask
//   - DONE_CNT_W  : width of the completed-invocation counter
// -----------------------------------------------------------------------------
package hls_drv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } drv_state_e;

    localparam int VLD_OUT13  = 0;
    localparam int VLD_OUT30  = 1;
    localparam int VLD_OUT31  = 2;
    localparam int VLD_W      = 3;

    localparam int DONE_CNT_W = 16;

endpackage : hls_drv_pkg

// File: rtl/hls_macc_drv_if.sv
// -----------------------------------------------------------------------------
// hls_macc_drv_if
// Bundles the host request/response channel and the kernel ap_ctrl_hs /
// result-strobe signals seen by hls_macc_drv.
//   modport master : the driver (drives req_ready, rsp_*, args_hold,
//                    done_cnt, k_ap_start)
//   modport slave  : the environment, host plus kernel (drives req_valid,
//                    rsp_ready and every k_* input of the driver)
// Parameter DATA_W : kernel result width.
// -----------------------------------------------------------------------------
interface hls_macc_drv_if #(
    parameter int DATA_W = 32
);
    // host side
    logic                               req_valid;
    logic                               req_ready;
    logic                               args_hold;
    logic                               rsp_valid;
    logic                               rsp_ready;
    logic [DATA_W-1:0]                  rsp_out13;
    logic [DATA_W-1:0]                  rsp_out30;
    logic [DATA_W-1:0]                  rsp_out31;
    logic [hls_drv_pkg::VLD_W-1:0]      rsp_vld_mask;
    logic                               rsp_timeout;
    logic [hls_drv_pkg::DONE_CNT_W-1:0] done_cnt;

    // kernel side
    logic                               k_ap_start;
    logic                               k_ap_done;
    logic                               k_ap_idle;
    logic                               k_ap_ready;
    logic [DATA_W-1:0]                  k_out13;
    logic                               k_out13_vld;
    logic [DATA_W-1:0]                  k_out30;
    logic                               k_out30_vld;
    logic [DATA_W-1:0]                  k_out31;
    logic                               k_out31_vld;

    modport master (
        input  req_valid, rsp_ready,
        input  k_ap_done, k_ap_idle, k_ap_ready,
        input  k_out13, k_out13_vld, k_out30, k_out30_vld, k_out31, k_out31_vld,
        output req_ready, args_hold, rsp_valid,
        output rsp_out13, rsp_out30, rsp_out31, rsp_vld_mask, rsp_timeout,
        output done_cnt, k_ap_start
    );

    modport slave (
        output req_valid, rsp_ready,
        output k_ap_done, k_ap_idle, k_ap_ready,
        output k_out13, k_out13_vld, k_out30, k_out30_vld, k_out31, k_out31_vld,
        input  req_ready, args_hold, rsp_valid,
        input  rsp_out13, rsp_out30, rsp_out31, rsp_vld_mask, rsp_timeout,
        input  done_cnt, k_ap_start
    );

endinterface : hls_macc_drv_if

// File: rtl/hls_drv_watchdog.sv
// -----------------------------------------------------------------------------
// hls_drv_watchdog
// Invocation watchdog for hls_macc_drv (only built with HLS_DRV_WATCHDOG_EN).
// Ports:
//   ap_clk, ap_rst : clock, asynchronous active-high reset
//   clr            : restart the count (request accepted)
//   en             : count this cycle (kernel running)
//   expire         : this cycle's increment brings the count to LIMIT-1
// Parameter LIMIT  : watchdog limit in cycles, legal range 2..65535.
// -----------------------------------------------------------------------------
module hls_drv_watchdog #(
    parameter int LIMIT = 64
) (
    input  logic ap_clk,
    input  logic ap_rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int CNT_W = (LIMIT > 2) ? $clog2(LIMIT) : 1;

    logic [CNT_W-1:0] cnt_q;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values, regardless of the order the always blocks run in.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // cnt_q holds the running cycles already completed; the cycle in which the
    // count would step to LIMIT-1 is the last one the kernel is granted, so the
    // response appears LIMIT cycles after the accept.
    assign expire = en && (cnt_q == CNT_W'(LIMIT - 2));

endmodule : hls_drv_watchdog

// File: rtl/hls_macc_drv.sv
// -----------------------------------------------------------------------------
// hls_macc_drv
// Caller-side ap_ctrl_hs controller for the HLS macc kernel family. Accepts a
// host request, launches the kernel via ap_start (held until ap_ready), keeps
// the kernel operands frozen through args_hold, captures out13 / out30_o /
// out31 on their _ap_vld strobes (last strobe wins) and returns them on a
// valid/ready response channel together with a strobe mask.
//
// Ports:
//   ap_clk, ap_rst : sole clock, asynchronous active-high reset
//   bus (master)   : hls_macc_drv_if - host request/response channel and the
//                    kernel control/result signals
// Parameters:
//   DATA_W         : kernel result width (must match the interface)
//   TIMEOUT_CYCLES : watchdog limit counted from launch, 2..65535
//
// Build option:
//   HLS_DRV_WATCHDOG_EN - when defined, a kernel that does not reach ap_done
//   within TIMEOUT_CYCLES is abandoned with rsp_timeout=1. When undefined the
//   driver waits for ap_done indefinitely and rsp_timeout is tied low.
// -----------------------------------------------------------------------------
module hls_macc_drv
    import hls_drv_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic           ap_clk,
    input  logic           ap_rst,
    hls_macc_drv_if.master bus
);

    drv_state_e state_q;
    drv_state_e state_d;

    logic [DATA_W-1:0]     out13_q;
    logic [DATA_W-1:0]     out30_q;
    logic [DATA_W-1:0]     out31_q;
    logic [VLD_W-1:0]      mask_q;
    logic [DONE_CNT_W-1:0] done_cnt_q;

    logic accept;
    logic busy;
    logic wd_expire;
    logic finish;

    assign busy   = (state_q == RUN) || (state_q == WAIT);
    assign accept = bus.req_valid && bus.req_ready;
    // An ap_done in the expiry cycle ends the invocation as a normal completion.
    assign finish = busy && (bus.k_ap_done || wd_expire);

`ifdef HLS_DRV_WATCHDOG_EN
    logic timeout_q;

    hls_drv_watchdog #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_watchdog (
        .ap_clk (ap_clk),
        .ap_rst (ap_rst),
        .clr    (accept),
        .en     (busy),
        .expire (wd_expire)
    );

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            timeout_q <= 1'b0;
        end else if (accept) begin
            timeout_q <= 1'b0;
        end else if (busy && wd_expire && !bus.k_ap_done) begin
            timeout_q <= 1'b1;
        end
    end

    assign bus.rsp_timeout = timeout_q;
`else
    assign wd_expire       = 1'b0;
    assign bus.rsp_timeout = 1'b0;
`endif

    // ---------------------------------------------------------------- FSM --
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: state_d gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (accept) state_d = RUN;
            RUN: begin
                if (finish) begin
                    state_d = RESP;
                end else if (bus.k_ap_ready) begin
                    // Kernel took the start but is still computing.
                    state_d = WAIT;
                end
            end
            WAIT: if (finish) state_d = RESP;
            RESP: if (bus.rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready  = (state_q == IDLE) && bus.k_ap_idle;
        bus.k_ap_start = (state_q == RUN);
        bus.args_hold  = busy;
        bus.rsp_valid  = (state_q == RESP);
    end

    // ----------------------------------------------------------- datapath --
    // Result registers only move on accept (clear) or while the kernel runs,
    // so the response fields are frozen for the whole RESP state.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            out13_q    <= '0;
            out30_q    <= '0;
            out31_q    <= '0;
            mask_q     <= '0;
            done_cnt_q <= '0;
        end else begin
            if (accept) begin
                out13_q <= '0;
                out30_q <= '0;
                out31_q <= '0;
                mask_q  <= '0;
            end else if (busy) begin
                if (bus.k_out13_vld) begin
                    out13_q           <= bus.k_out13;
                    mask_q[VLD_OUT13] <= 1'b1;
                end
                if (bus.k_out30_vld) begin
                    out30_q           <= bus.k_out30;
                    mask_q[VLD_OUT30] <= 1'b1;
                end
                if (bus.k_out31_vld) begin
                    out31_q           <= bus.k_out31;
                    mask_q[VLD_OUT31] <= 1'b1;
                end
            end
            if (finish) begin
                done_cnt_q <= done_cnt_q + 1'b1;
            end
        end
    end

    assign bus.rsp_out13    = out13_q;
    assign bus.rsp_out30    = out30_q;
    assign bus.rsp_out31    = out31_q;
    assign bus.rsp_vld_mask = mask_q;
    assign bus.done_cnt     = done_cnt_q;

endmodule : hls_macc_drv

// File: tb/tb_hls_macc_drv.sv
// -----------------------------------------------------------------------------
// tb_hls_macc_drv
// Self-checking bench for hls_macc_drv. A cycle-driven kernel stand-in is
// played from the bench; the expected response of every invocation is derived
// from the strobe schedule (last strobe per output wins, end cycle is the done
// cycle or the watchdog deadline) and compared with the DUT.
// Watchdog scenarios are exercised when HLS_DRV_WATCHDOG_EN is defined.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_hls_macc_drv;

    localparam int DW = 32;
    localparam int TO = 8;

`ifdef HLS_DRV_WATCHDOG_EN
    localparam bit WD_EN = 1'b1;
`else
    localparam bit WD_EN = 1'b0;
`endif

    logic ap_clk = 1'b0;
    logic ap_rst = 1'b1;

    int total = 0;
    int bad   = 0;
    logic [15:0] exp_done = '0;

    hls_macc_drv_if #(.DATA_W(DW)) bus ();

    hls_macc_drv #(
        .DATA_W         (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .ap_clk (ap_clk),
        .ap_rst (ap_rst),
        .bus    (bus)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic next_cycle();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic kernel_quiet();
        bus.k_ap_done   = 1'b0;
        bus.k_ap_ready  = 1'b0;
        bus.k_out13_vld = 1'b0;
        bus.k_out30_vld = 1'b0;
        bus.k_out31_vld = 1'b0;
    endtask

    // One complete invocation: accept, kernel activity from cycle 1 through the
    // expected end cycle, response held for 'hold' extra cycles, then consumed.
    // done_at/ready_at are cycle numbers after the accept (cycle 0).
    task automatic invoke(input string name, input int done_at, input int ready_at,
                          input bit rand_strb, input logic [2:0] fix_mask,
                          input int fix_cyc, input logic [31:0] f13,
                          input logic [31:0] f30, input logic [31:0] f31,
                          input int hold);
        logic [31:0]  e13 = '0;
        logic [31:0]  e30 = '0;
        logic [31:0]  e31 = '0;
        logic [2:0]   emask = '0;
        logic         etimeout = 1'b0;
        logic [116:0] got, want;
        int           end_c;

        end_c = done_at;
        if (WD_EN && done_at > TO - 1) begin
            end_c    = TO - 1;
            etimeout = 1'b1;
        end

        bus.req_valid = 1'b1;
        bus.k_ap_idle = 1'b1;
        @(negedge ap_clk);
        total++;
        if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL %s accept: req_ready=%b rsp_valid=%b want 1/0",
                     name, bus.req_ready, bus.rsp_valid);
        end
        next_cycle();
        bus.req_valid = 1'b0;
        bus.k_ap_idle = 1'b0;

        for (int c = 1; c <= end_c; c++) begin
            bit s13, s30, s31;
            logic [31:0] v13, v30, v31;
            if (rand_strb) begin
                s13 = ($urandom_range(0, 2) == 0);
                s30 = ($urandom_range(0, 2) == 0);
                s31 = ($urandom_range(0, 2) == 0);
                v13 = $urandom;
                v30 = $urandom;
                v31 = $urandom;
            end else begin
                s13 = (c == fix_cyc) && fix_mask[0];
                s30 = (c == fix_cyc) && fix_mask[1];
                s31 = (c == fix_cyc) && fix_mask[2];
                v13 = s13 ? f13 : $urandom;
                v30 = s30 ? f30 : $urandom;
                v31 = s31 ? f31 : $urandom;
            end
            bus.k_ap_done   = (c == done_at);
            bus.k_ap_ready  = (c == ready_at) || (c == done_at);
            bus.k_out13_vld = s13;
            bus.k_out30_vld = s30;
            bus.k_out31_vld = s31;
            bus.k_out13     = v13;
            bus.k_out30     = v30;
            bus.k_out31     = v31;
            if (s13) begin e13 = v13; emask[0] = 1'b1; end
            if (s30) begin e30 = v30; emask[1] = 1'b1; end
            if (s31) begin e31 = v31; emask[2] = 1'b1; end
            @(negedge ap_clk);
            total++;
            if (bus.k_ap_start !== (c <= ready_at) || bus.args_hold !== 1'b1 ||
                bus.rsp_valid !== 1'b0) begin
                bad++;
                $display("FAIL %s run c%0d: start/hold/rsp_valid=%b%b%b want %b10",
                         name, c, bus.k_ap_start, bus.args_hold, bus.rsp_valid,
                         (c <= ready_at));
            end
            next_cycle();
        end

        kernel_quiet();
        bus.k_ap_idle = 1'b1;
        bus.rsp_ready = 1'b0;
        bus.req_valid = (hold > 0);
        exp_done      = exp_done + 16'd1;
        want = {1'b1, etimeout, emask, e13, e30, e31, exp_done};

        for (int h = 0; h <= hold; h++) begin
            if (h > 0) next_cycle();
            @(negedge ap_clk);
            got = {bus.rsp_valid, bus.rsp_timeout, bus.rsp_vld_mask, bus.rsp_out13,
                   bus.rsp_out30, bus.rsp_out31, bus.done_cnt};
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL %s resp h%0d: got %h want %h (vld,to,mask,o13,o30,o31,cnt)",
                         name, h, got, want);
            end
            total++;
            if (bus.req_ready !== 1'b0 || bus.k_ap_start !== 1'b0 ||
                bus.args_hold !== 1'b0) begin
                bad++;
                $display("FAIL %s resp ctl h%0d: req_ready/start/hold=%b%b%b want 000",
                         name, h, bus.req_ready, bus.k_ap_start, bus.args_hold);
            end
        end
        bus.rsp_ready = 1'b1;
        next_cycle();
        bus.rsp_ready = 1'b0;
        bus.req_valid = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge ap_clk);
        total++;
        if ({bus.k_ap_start, bus.args_hold, bus.rsp_valid, bus.rsp_timeout,
             bus.rsp_vld_mask, bus.done_cnt, bus.req_ready} !== 24'h0) begin
            bad++;
            $display("FAIL reset_outputs: start=%b hold=%b rsp_valid=%b to=%b mask=%b cnt=%0d rdy=%b",
                     bus.k_ap_start, bus.args_hold, bus.rsp_valid, bus.rsp_timeout,
                     bus.rsp_vld_mask, bus.done_cnt, bus.req_ready);
        end
        total++;
        if ({bus.rsp_out13, bus.rsp_out30, bus.rsp_out31} !== 96'h0) begin
            bad++;
            $display("FAIL reset_results: got %h want 0",
                     {bus.rsp_out13, bus.rsp_out30, bus.rsp_out31});
        end
        bus.k_ap_idle = 1'b1;
        #1;
        total++;
        if (bus.req_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_req_ready: got %b want 1", bus.req_ready);
        end
        ap_rst = 1'b0;
        next_cycle();
    endtask

    task automatic test_kernel_busy();
        bus.k_ap_idle = 1'b0;
        bus.req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge ap_clk);
            total++;
            if (bus.req_ready !== 1'b0 || bus.k_ap_start !== 1'b0) begin
                bad++;
                $display("FAIL busy_kernel %0d: req_ready=%b start=%b want 0/0",
                         i, bus.req_ready, bus.k_ap_start);
            end
            next_cycle();
        end
        bus.req_valid = 1'b0;
        bus.k_ap_idle = 1'b1;
    endtask

    task automatic test_nominal();
        invoke("nominal", 4, 4, 1'b0, 3'b111, 4, 32'h11, 32'h22, 32'h33, 0);
    endtask

    task automatic test_partial();
        invoke("partial", 4, 2, 1'b0, 3'b100, 3, 32'h0, 32'h0, 32'hDEAD, 0);
    endtask

    task automatic test_watchdog();
        if (WD_EN) begin
            invoke("hung", 1000, 1000, 1'b1, 3'b000, 0, '0, '0, '0, 0);
            invoke("done_at_expiry", TO - 1, TO - 1, 1'b1, 3'b000, 0, '0, '0, '0, 0);
            invoke("hung_after_ready", 1000, 3, 1'b1, 3'b000, 0, '0, '0, '0, 0);
        end else begin
            invoke("long_run", 20, 3, 1'b1, 3'b000, 0, '0, '0, '0, 0);
        end
    endtask

    task automatic test_back_to_back();
        invoke("backpressure", 6, 2, 1'b1, 3'b000, 0, '0, '0, '0, 5);
        invoke("b2b_next", 3, 1, 1'b1, 3'b000, 0, '0, '0, '0, 0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 12; n++) begin
            int d, r;
            d = $urandom_range(1, 12);
            r = $urandom_range(1, d);
            invoke("random", d, r, 1'b1, 3'b000, 0, '0, '0, '0, $urandom_range(0, 3));
        end
    endtask

    task automatic test_reset_mid();
        bus.req_valid = 1'b1;
        bus.k_ap_idle = 1'b1;
        next_cycle();
        bus.req_valid  = 1'b0;
        bus.k_ap_idle  = 1'b0;
        bus.k_ap_ready = 1'b1;
        next_cycle();
        bus.k_ap_ready = 1'b0;
        #2;
        total++;
        if (bus.args_hold !== 1'b1 || bus.k_ap_start !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid pre (WAIT): hold=%b start=%b want 1/0",
                     bus.args_hold, bus.k_ap_start);
        end
        ap_rst = 1'b1;
        exp_done = '0;
        #1;
        total++;
        if (bus.args_hold !== 1'b0 || bus.k_ap_start !== 1'b0 ||
            bus.rsp_valid !== 1'b0 || bus.done_cnt !== exp_done) begin
            bad++;
            $display("FAIL rst_mid async: hold=%b start=%b rsp_valid=%b cnt=%0d want 0/0/0/0",
                     bus.args_hold, bus.k_ap_start, bus.rsp_valid, bus.done_cnt);
        end
        @(negedge ap_clk);
        ap_rst = 1'b0;
        bus.k_ap_idle = 1'b1;
        bus.k_ap_done = 1'b1;
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            bus.k_ap_done = 1'b0;
            @(negedge ap_clk);
            total++;
            if (bus.rsp_valid !== 1'b0 || bus.done_cnt !== exp_done ||
                bus.req_ready !== 1'b1) begin
                bad++;
                $display("FAIL rst_mid after %0d: rsp_valid=%b cnt=%0d req_ready=%b want 0/0/1",
                         i, bus.rsp_valid, bus.done_cnt, bus.req_ready);
            end
        end
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b0;
        bus.k_ap_idle = 1'b0;
        bus.k_out13   = '0;
        bus.k_out30   = '0;
        bus.k_out31   = '0;
        kernel_quiet();

        test_reset();
        test_kernel_busy();
        test_nominal();
        test_partial();
        test_watchdog();
        test_back_to_back();
        test_random();
        test_reset_mid();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation bound reached");
        $fatal(1, "bench did not complete");
    end

endmodule : tb_hls_macc_drv

// File: doc/hls_macc_drv.md
# hls_macc_drv

Caller-side controller for the `ap_ctrl_hs` block-level handshake used by our HLS kernels, the macc kernel family in particular. It accepts a host request over a valid/ready channel and launches the kernel through `ap_start`. While the kernel runs it collects the `out13`, `out30_o` and `out31` results via their `_ap_vld` strobes, then returns them on a valid/ready response channel. An optional watchdog stops a kernel whose FSM never reaches done, for example a key-locked kernel, from hanging the host.

## Interface
Parameters:
- `DATA_W`, 32: kernel result width.
- `TIMEOUT_CYCLES`, 64: watchdog limit in cycles, counted from launch. Legal range 2..65535.

Ports:
- `ap_clk` in, 1: sole clock.
- `ap_rst` in, 1: reset, asynchronous, active-high.
- `req_valid` in, 1: host requests one kernel invocation.
- `req_ready` out, 1: driver can accept a request.
- `args_hold` out, 1: upstream must hold kernel `in*` operands stable while this is high.
- `rsp_valid` out, 1: response available.
- `rsp_ready` in, 1: host consumes the response.
- `rsp_out13` out, DATA_W: captured `out13`.
- `rsp_out30` out, DATA_W: captured `out30_o`.
- `rsp_out31` out, DATA_W: captured `out31`.
- `rsp_vld_mask` out, 3: bits [0..2] set if `out13`, `out30`, `out31` respectively were strobed.
- `rsp_timeout` out, 1: invocation aborted by the watchdog.
- `done_cnt` out, 16: completed-invocation counter, wraps at 2^16.
- `k_ap_start` out, 1: to kernel `ap_start`.
- `k_ap_done` in, 1: from kernel `ap_done`.
- `k_ap_idle` in, 1: from kernel `ap_idle`.
- `k_ap_ready` in, 1: from kernel `ap_ready`.
- `k_out13` in, DATA_W: from kernel `out13`.
- `k_out13_vld` in, 1: from kernel `out13_ap_vld`.
- `k_out30` in, DATA_W: from kernel `out30_o`.
- `k_out30_vld` in, 1: from kernel `out30_o_ap_vld`.
- `k_out31` in, DATA_W: from kernel `out31`.
- `k_out31_vld` in, 1: from kernel `out31_ap_vld`.

## Operation
- FSM states: IDLE, RUN, WAIT, RESP.
  - IDLE → RUN when `req_valid & req_ready`. `req_ready` equals `(state==IDLE) & k_ap_idle`.
  - RUN → RESP when `k_ap_done`. RUN → WAIT when `k_ap_ready & !k_ap_done`.
  - WAIT → RESP when `k_ap_done`.
  - RESP → IDLE when `rsp_ready`.
- Outputs decoded from state:
  - `k_ap_start` = (state==RUN).
  - `args_hold` = (state==RUN or WAIT).
  - `rsp_valid` = (state==RESP).
- Request accept clears all result registers, `rsp_vld_mask` and `rsp_timeout`.
- Result capture in RUN/WAIT:
  - Each `k_outN_vld` high loads the matching result register and sets its mask bit.
  - A later strobe overwrites, so the last value wins.
  - A strobe coincident with `k_ap_done` is captured.
- `done_cnt` increments on each RUN/WAIT → RESP transition, timeouts included.
- Response fields stay stable for the whole RESP state.

## Timing
- Reset values: state IDLE; `k_ap_start`, `args_hold`, `rsp_valid`, `rsp_timeout` 0; result registers, mask and `done_cnt` 0. `req_ready` follows `k_ap_idle`.
- Assertion of `ap_rst` forces IDLE asynchronously, including mid-invocation. `k_ap_start` drops in the same cycle and no response is produced.
- Latency against the 4-state macc kernel:
  - Accept in cycle 0.
  - `k_ap_start` high in cycles 1–4.
  - Kernel `ap_done`/`ap_ready` in cycle 4.
  - `rsp_valid` from cycle 5.
- `k_ap_start` holds high until `ap_ready` is sampled, per `ap_ctrl_hs`.
- Watchdog:
  - Counter is cleared on accept and increments every RUN/WAIT cycle.
  - When it reaches TIMEOUT_CYCLES−1 without `k_ap_done`, the FSM goes to RESP with `rsp_timeout`=1 and `k_ap_start` deasserts.
- `k_ap_done` in the same cycle as the timeout: done wins and `rsp_timeout`=0.
- A request while the kernel is not idle is not accepted, because `req_ready`=0.
- Back-to-back: the earliest next accept is the cycle after `rsp_ready`.

## Configuration
- `HLS_DRV_WATCHDOG_EN` defined: watchdog present as described above.
- Not defined:
  - Counter logic removed.
  - `rsp_timeout` tied 0.
  - RUN/WAIT wait indefinitely for `k_ap_done`.
  - `TIMEOUT_CYCLES` is ignored.

## Structure
- Package `hls_drv_pkg`:
  - state enum (IDLE/RUN/WAIT/RESP).
  - mask bit index constants `VLD_OUT13=0`, `VLD_OUT30=1`, `VLD_OUT31=2`.
  - `DONE_CNT_W=16`.
- Sub-module `hls_drv_watchdog`: clear/enable/expire counter, instantiated only under `HLS_DRV_WATCHDOG_EN`.

## Test plan
- Nominal run:
  - Stimulus: kernel model asserts done/ready/all vld in cycle 4 with out13=0x11, out30=0x22, out31=0x33.
  - Required: `rsp_valid` in cycle 5, mask=3'b111, timeout=0, `done_cnt`=1.
- Partial strobes:
  - Stimulus: only `out31_vld` asserted, value 0xDEAD.
  - Required: `rsp_out31`=0xDEAD, mask=3'b100, other result fields 0.
- Hung kernel:
  - Stimulus: TIMEOUT_CYCLES=8, kernel never asserts done.
  - Required: `rsp_valid` 8 cycles after accept, `rsp_timeout`=1, `k_ap_start`=0, `done_cnt`=1.
- Done coincident with timeout:
  - Stimulus: done asserted on the expiry cycle.
  - Required: `rsp_timeout`=0 and results captured.
- Response backpressure:
  - Stimulus: `rsp_ready` low for 5 cycles.
  - Required: response fields stable, `req_ready`=0 throughout, and the next request accepted the cycle after `rsp_ready`.
- Reset mid-operation:
  - Stimulus: `ap_rst` pulsed in WAIT.
  - Required: `k_ap_start`/`args_hold` 0 immediately, no `rsp_valid`, `done_cnt`=0.
